ad7946_ctrl: RTL and testbench

AD7946_CTRL -- requirements
Module: ad7946_ctrl

---
 rtl/ad7946_ctrl.sv | 155 +++++++++++++++
 tb/tb_ad7946_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7946_ctrl.sv
// AD7946 SAR ADC controller: power-down/wake sequencing, continuous conversion
// frames with 16-clock serial readback, channel selection and channel-tag check.
module ad7946_ctrl #(
   parameter int CLK_DIV      = 2,
   parameter int QUIET_CYCLES = 40,
   parameter int WAKE_CYCLES  = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  chan_mode,
   output logic        pden,
   output logic        chsel,
   output logic        cs_n,
   output logic        sclk,
   input  logic        sdo,
   output logic [11:0] m_data,
   output logic        m_chan,
   output logic        m_valid,
   output logic        tag_err,
   output logic [15:0] frame_cnt,
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAKE  = 3'd1,
      SETUP = 3'd2,
      SHIFT = 3'd3,
      QUIET = 3'd4
   } state_t;

   localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [15:0] WAKE_LAST  = 16'(WAKE_CYCLES - 1);
   localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYCLES - 1);
   // 33 half-periods: one leading low phase, then 16 high/low pulse pairs.
   localparam logic [5:0]  PH_LAST    = 6'd32;

   state_t      state;
   logic [15:0] wait_cnt;
   logic [7:0]  div_cnt;
   logic [5:0]  phase;
   logic [15:0] shreg;
   logic        pend_chan;
   logic        alt_chan;
   logic        next_chan;

   always_comb begin
      next_chan = 1'b0;
      case (chan_mode)
         2'b00:   next_chan = 1'b0;
         2'b01:   next_chan = 1'b1;
         default: next_chan = alt_chan;
      endcase
   end

   assign fsm_state = state;

   // Result port: m_valid is a one-cycle strobe with no ready/backpressure;
   // m_data, m_chan and tag_err are qualified by it, data/chan hold until the next strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pden      <= 1'b1;
         cs_n      <= 1'b1;
         sclk      <= 1'b0;
         chsel     <= 1'b0;
         m_data    <= 12'd0;
         m_chan    <= 1'b0;
         m_valid   <= 1'b0;
         tag_err   <= 1'b0;
         frame_cnt <= 16'd0;
         wait_cnt  <= 16'd0;
         div_cnt   <= 8'd0;
         phase     <= 6'd0;
         shreg     <= 16'd0;
         pend_chan <= 1'b0;
         alt_chan  <= 1'b0;
      end else begin
         m_valid <= 1'b0;
         tag_err <= 1'b0;
         case (state)
            IDLE: begin
               pden <= 1'b1;
               cs_n <= 1'b1;
               sclk <= 1'b0;
               if (enable) begin
                  state    <= WAKE;
                  pden     <= 1'b0;
                  wait_cnt <= 16'd0;
                  alt_chan <= 1'b0;
               end
            end
            WAKE: begin
               if (wait_cnt == WAKE_LAST) begin
                  wait_cnt <= 16'd0;
                  state    <= SETUP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            SETUP: begin
               chsel     <= next_chan;
               pend_chan <= next_chan;
               cs_n      <= 1'b0;
               sclk      <= 1'b0;
               div_cnt   <= 8'd0;
               phase     <= 6'd0;
               state     <= SHIFT;
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= 8'd0;
                  if (phase == PH_LAST) begin
                     cs_n      <= 1'b1;
                     sclk      <= 1'b0;
                     m_valid   <= 1'b1;
                     m_data    <= shreg[13:2];
                     m_chan    <= pend_chan;
                     tag_err   <= shreg[14] ^ pend_chan;
                     frame_cnt <= frame_cnt + 16'd1;
                     alt_chan  <= ~pend_chan;
                     wait_cnt  <= 16'd0;
                     state     <= QUIET;
                  end else begin
                     phase <= phase + 6'd1;
                     sclk  <= ~phase[0];
                     // sdo is captured on the same edge that raises sclk
                     if (!phase[0]) begin
                        shreg <= {shreg[14:0], sdo};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            QUIET: begin
               if (wait_cnt == QUIET_LAST) begin
                  wait_cnt <= 16'd0;
                  if (enable) begin
                     state <= SETUP;
                  end else begin
                     state <= IDLE;
                     pden  <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad7946_ctrl.sv
// Bench for ad7946_ctrl: timeline model of the conversion frames, ADC serial
// model, per-cycle output compare and directed scenarios with literal expectations.
module tb_ad7946_ctrl;

   localparam int D = 2;
   localparam int Q = 40;
   localparam int W = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  chan_mode = 2'b00;
   logic        sdo = 1'b0;
   logic        pden, chsel, cs_n, sclk, m_chan, m_valid, tag_err;
   logic [11:0] m_data;
   logic [15:0] frame_cnt;
   logic [2:0]  fsm_state;

   ad7946_ctrl #(.CLK_DIV(D), .QUIET_CYCLES(Q), .WAKE_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .enable(enable), .chan_mode(chan_mode),
      .pden(pden), .chsel(chsel), .cs_n(cs_n), .sclk(sclk), .sdo(sdo),
      .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .tag_err(tag_err),
      .frame_cnt(frame_cnt), .fsm_state(fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard bookkeeping ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle time %0t)", name, act, exp, $time);
      end
   endtask

   // stimulus-side ADC contents
   logic [15:0] adc_word = 16'h0000;
   logic        echo_tag = 1'b1;
   int          pre_tok = 0;
   bit          chk_en = 1'b0;

   // ---------------- ADC serial model ----------------
   int          rises = 0;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic [15:0] frame_word = 16'h0000;

   always @(negedge clk) begin
      if (cs_n !== 1'b0) begin
         rises = 0;
         sdo = 1'b0;
      end else begin
         if (prev_cs) frame_word = echo_tag ? {adc_word[15], chsel, adc_word[13:0]} : adc_word;
         if (sclk && !prev_sclk) rises++;
         sdo = (rises < 16) ? frame_word[15 - rises] : 1'b0;
      end
      prev_cs = cs_n;
      prev_sclk = sclk;
   end

   // ---------------- timeline model ----------------
   // f is the edge index at which cs_n must fall; everything in a frame is an
   // offset from it.
   int          cyc = 0;
   bit          running = 1'b0;
   int          f = 0;
   int          rel = 0;
   bit          alt_next = 1'b0;
   int          pre_seen = 0;
   logic        e_pden = 1'b1, e_cs = 1'b1, e_sclk = 1'b0, e_chsel = 1'b0;
   logic        e_mchan = 1'b0, e_valid = 1'b0, e_tag = 1'b0;
   logic [11:0] e_data = 12'd0;
   logic [15:0] e_cnt = 16'd0;
   logic [15:0] e_word;
   logic [13:0] exp_q[$];

   always @(posedge clk) begin
      cyc++;
      e_valid = 1'b0;
      e_tag = 1'b0;
      if (pre_tok != pre_seen) begin
         pre_seen = pre_tok;
         e_cnt = 16'hFFFF;
      end
      if (reset) begin
         running = 1'b0;
         e_pden = 1'b1; e_cs = 1'b1; e_sclk = 1'b0; e_chsel = 1'b0;
         e_data = 12'd0; e_mchan = 1'b0; e_cnt = 16'd0;
      end else if (!running) begin
         if (enable) begin
            running = 1'b1;
            f = cyc + W + 1;
            e_pden = 1'b0;
            alt_next = 1'b0;
         end
      end else begin
         rel = cyc - f;
         if (rel == 0)
            e_chsel = (chan_mode == 2'b00) ? 1'b0 : (chan_mode == 2'b01) ? 1'b1 : alt_next;
         if (rel >= 0 && rel < 33 * D) begin
            e_cs = 1'b0;
            e_sclk = (rel >= D) && ((rel / D) % 2 == 1);
         end else if (rel == 33 * D) begin
            e_word = echo_tag ? {adc_word[15], e_chsel, adc_word[13:0]} : adc_word;
            e_cs = 1'b1; e_sclk = 1'b0; e_valid = 1'b1;
            e_data = e_word[13:2];
            e_mchan = e_chsel;
            e_tag = e_word[14] ^ e_chsel;
            e_cnt = e_cnt + 16'd1;
            alt_next = !e_chsel;
            exp_q.push_back({e_tag, e_chsel, e_data});
         end else if (rel == 33 * D + Q) begin
            if (enable) f = cyc + 1;
            else begin
               running = 1'b0;
               e_pden = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("pins", 32'({pden, cs_n, sclk, chsel}), 32'({e_pden, e_cs, e_sclk, e_chsel}));
         check("strobes", 32'({m_valid, tag_err}), 32'({e_valid, e_tag}));
         check("result", 32'({m_data, m_chan}), 32'({e_data, e_mchan}));
         check("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
         if (m_valid === 1'b1) begin
            check("valid_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("valid_result", 32'({tag_err, m_chan, m_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- event log ----------------
   int          fall_q[$], rise_q[$], valid_q[$], pden_rise_q[$];
   logic [11:0] vdata_q[$];
   logic        vchan_q[$], vtag_q[$];
   logic        l_cs = 1'b1, l_sclk = 1'b0, l_pden = 1'b1;

   always @(posedge clk) begin
      #1;
      if (cs_n === 1'b0 && l_cs === 1'b1) fall_q.push_back(cyc);
      if (sclk === 1'b1 && l_sclk === 1'b0) rise_q.push_back(cyc);
      if (pden === 1'b1 && l_pden === 1'b0) pden_rise_q.push_back(cyc);
      if (m_valid === 1'b1) begin
         valid_q.push_back(cyc);
         vdata_q.push_back(m_data);
         vchan_q.push_back(m_chan);
         vtag_q.push_back(tag_err);
      end
      l_cs = cs_n;
      l_sclk = sclk;
      l_pden = pden;
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      fall_q.delete(); rise_q.delete(); valid_q.delete(); pden_rise_q.delete();
      vdata_q.delete(); vchan_q.delete(); vtag_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_logs();
   endtask

   function automatic int log_size(int which);
      case (which)
         0:       return valid_q.size();
         1:       return fall_q.size();
         default: return rise_q.size();
      endcase
   endfunction

   task automatic wait_log(string name, int which, int n, int lim);
      int k = 0;
      while (log_size(which) < n && k < lim) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(log_size(which) >= n), 32'd1);
   endtask

   task automatic wait_pden(string name, int lim);
      int k = 0;
      while (pden !== 1'b1 && k < lim) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(pden), 32'd1);
   endtask

   function automatic int rises_before(int lim);
      int c = 0;
      foreach (rise_q[i]) if (rise_q[i] < lim) c++;
      return c;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: summary not reached by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int en_cyc;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_pins", 32'({pden, cs_n, sclk, chsel, m_valid, tag_err}), 32'b110000);
      check("rst_cnt", 32'(frame_cnt), 32'd0);
      check("rst_data", 32'({m_data, m_chan}), 32'd0);

      // ch0 only, two frames: wake latency, sclk shape, period, result
      clear_logs();
      chan_mode = 2'b00; echo_tag = 1'b1; adc_word = 16'h1234;
      en_cyc = cyc + 1;
      enable = 1'b1;
      wait_log("t1_wait_valid", 0, 2, 700);
      enable = 1'b0;
      wait_pden("t1_idle", 200);
      check("t1_fall_delay", fall_q[0] - en_cyc, 101);
      check("t1_first_rise", rise_q[0] - fall_q[0], 2);
      check("t1_sclk_period", rise_q[1] - rise_q[0], 4);
      check("t1_pulse16_span", rise_q[15] - rise_q[0], 60);
      check("t1_pulse_count", rises_before(valid_q[0]), 16);
      check("t1_valid_delay", valid_q[0] - fall_q[0], 66);
      check("t1_frame_period", fall_q[1] - fall_q[0], 107);
      check("t1_chan", 32'(vchan_q[0]), 32'd0);
      check("t1_data", 32'(vdata_q[0]), 32'h48D);
      check("t1_tag", 32'(vtag_q[0]), 32'd0);
      check("t1_quiet_to_idle", pden_rise_q[0] - valid_q[1], 40);

      // alternating channels over four frames
      do_reset();
      chan_mode = 2'b10; echo_tag = 1'b1; adc_word = 16'h8001;
      enable = 1'b1;
      wait_log("t2_wait_valid", 0, 4, 900);
      enable = 1'b0;
      wait_pden("t2_idle", 200);
      check("t2_chan_seq", 32'({vchan_q[0], vchan_q[1], vchan_q[2], vchan_q[3]}), 32'b0101);
      check("t2_tags", 32'({vtag_q[0], vtag_q[1], vtag_q[2], vtag_q[3]}), 32'd0);
      check("t2_frame_cnt", 32'(frame_cnt), 32'd4);
      check("t2_frames", fall_q.size(), 4);

      // forced mismatching tag with payload 0xA5C on ch0
      do_reset();
      chan_mode = 2'b00; echo_tag = 1'b0; adc_word = 16'h6970;
      enable = 1'b1;
      wait_log("t3_wait_fall", 1, 1, 300);
      enable = 1'b0;
      wait_log("t3_wait_valid", 0, 1, 200);
      wait_pden("t3_idle", 200);
      check("t3_data", 32'(vdata_q[0]), 32'hA5C);
      check("t3_tag_err", 32'(vtag_q[0]), 32'd1);
      check("t3_chan", 32'(vchan_q[0]), 32'd0);

      // enable dropped at the 5th sclk pulse on ch1
      do_reset();
      chan_mode = 2'b01; echo_tag = 1'b1; adc_word = 16'h0FF0;
      enable = 1'b1;
      wait_log("t4_wait_rise5", 2, 5, 300);
      enable = 1'b0;
      wait_pden("t4_idle", 300);
      repeat (20) @(negedge clk);
      check("t4_valids", valid_q.size(), 1);
      check("t4_frames", fall_q.size(), 1);
      check("t4_chan", 32'(vchan_q[0]), 32'd1);
      check("t4_data", 32'(vdata_q[0]), 32'h3FC);
      check("t4_quiet_to_idle", pden_rise_q[0] - valid_q[0], 40);
      check("t4_pden", 32'({pden, cs_n}), 32'b11);

      // reset pulse at the 8th sclk pulse of the second frame
      do_reset();
      chan_mode = 2'b00; echo_tag = 1'b1; adc_word = 16'h1234;
      enable = 1'b1;
      wait_log("t5_wait_valid", 0, 1, 400);
      clear_logs();
      wait_log("t5_wait_rise8", 2, 8, 300);
      reset = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("t5_abort_pins", 32'({cs_n, sclk, m_valid, pden}), 32'b1001);
      check("t5_abort_cnt", 32'(frame_cnt), 32'd0);
      reset = 1'b0;
      clear_logs();
      repeat (200) @(negedge clk);
      check("t5_no_valid", valid_q.size(), 0);
      check("t5_no_frame", fall_q.size(), 0);

      // frame_cnt wrap: counter deposited at 0xFFFF, then one frame
      pre_tok++;
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      @(negedge clk);
      check("t6_preload", 32'(frame_cnt), 32'hFFFF);
      clear_logs();
      enable = 1'b1;
      wait_log("t6_wait_fall", 1, 1, 300);
      enable = 1'b0;
      wait_log("t6_wait_valid", 0, 1, 200);
      check("t6_wrap", 32'(frame_cnt), 32'd0);
      wait_pden("t6_idle", 200);

      check("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
